// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the button debouncer.
//   state_e     : per-channel debounce FSM state (2-bit)
//   SYNC_STAGES : depth of the metastability synchroniser chain
package button_debounce_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_e;

endpackage : button_debounce_pkg

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, debounce FSM with stability
// counter, registered level and press/release pulses, optional long-press.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (adds hold counter).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw_i       : raw pin, already polarity-corrected (1 = pressed)
//   level_o     : debounced level
//   press_o     : 1-cycle pulse on accepted press
//   release_o   : 1-cycle pulse on accepted release
//   long_o      : 1-cycle long-press pulse (0 without the feature)
module button_debounce_chan
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES     = 200000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;

    // Synchroniser: shift raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Debounce FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Debounce FSM next state: a change is accepted only after the
    // synchronised level has held for DEBOUNCE_CYCLES counted cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (sync_lvl) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!sync_lvl) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync_lvl) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (sync_lvl) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;

    // Hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    // Count while the debounced level is high; saturate and fire once.
    always_comb begin
        hold_d      = hold_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (!level_q) begin
            hold_d      = '0;
            long_done_d = 1'b0;
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
        end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule : button_debounce_chan

// File: rtl/button_debounce.sv
// Button input conditioning: optional polarity inversion, then NUM_BTN
// independent synchronise/debounce channels.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (btn_long pulses;
// otherwise btn_long is tied 0).
// Ports:
//   clk, rst_n   : fabric clock, asynchronous active-low reset
//   button       : raw asynchronous pushbutton pins
//   btn_level    : debounced level per channel, 1 = pressed
//   btn_press    : 1-cycle pulse on accepted press
//   btn_release  : 1-cycle pulse on accepted release
//   btn_long     : 1-cycle long-press pulse
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned LONG_CYCLES     = 200000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] button,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES
        || SYNC_STAGES < 2) begin : g_bad_params
        $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
    end

    logic [NUM_BTN-1:0] button_pol;

    // Normalise so that 1 always means pressed before synchronising.
    assign button_pol = ACTIVE_LOW ? ~button : button;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            ,
            .LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_i     (button_pol[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .long_o    (btn_long[i])
        );
    end

endmodule : button_debounce
